// File: rtl/conv_8a32_rx_pkg.sv
// -----------------------------------------------------------------------------
// conv_8a32_rx_pkg
// Shared constants and types for the receive-side 8-to-32 byte packer.
//   - PCLK width-select encodings (W32 / W16 / W8; 2'b11 behaves as W8)
//   - COM_SYM : K-symbol that marks byte lane 0 of a word
//   - OUT_W   : output word width (fixed)
//   - state_t : alignment FSM states
//   - last_lane() : index of the final byte lane for a given width select
// -----------------------------------------------------------------------------
package conv_8a32_rx_pkg;

   localparam logic [1:0] W32 = 2'b00;
   localparam logic [1:0] W16 = 2'b01;
   localparam logic [1:0] W8  = 2'b10;

   localparam logic [7:0] COM_SYM = 8'hBC;
   localparam int         OUT_W   = 32;

   typedef enum logic {
      UNALIGNED = 1'b0,
      ALIGNED   = 1'b1
   } state_t;

   // Lane index of the last byte of a word (N-1); reserved 2'b11 acts as 8-bit.
   function automatic logic [1:0] last_lane(input logic [1:0] pclk);
      logic [1:0] l;
      case (pclk)
         W32:     l = 2'd3;
         W16:     l = 2'd1;
         default: l = 2'd0;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/conv_8a32_lane_ctrl.sv
// -----------------------------------------------------------------------------
// conv_8a32_lane_ctrl
// Byte counter for the packer: tracks which lane the next symbol lands in,
// detects width-select changes and flags the byte that completes a word.
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     synchronous active-low reset
//   i_consume   the current symbol is written into a lane this cycle
//   i_restart   force the current symbol to lane 0 (COM alignment)
//   i_pclk      width select
//   o_pos       counter position ignoring i_restart (0 on a width change)
//   o_lane      lane the current symbol is written to
//   o_word_done current consumed symbol is the last byte of a word
// -----------------------------------------------------------------------------
module conv_8a32_lane_ctrl
   import conv_8a32_rx_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_consume,
   input  logic       i_restart,
   input  logic [1:0] i_pclk,
   output logic [1:0] o_pos,
   output logic [1:0] o_lane,
   output logic       o_word_done
);

   logic [1:0] r_cnt;
   logic [1:0] r_pclk_prev;
   logic       w_pclk_chg;
   logic [1:0] w_cnt_nxt;

   // A width change restarts the word: the symbol on that cycle is lane 0.
   assign w_pclk_chg  = (i_pclk != r_pclk_prev);
   assign o_pos       = w_pclk_chg ? 2'd0 : r_cnt;
   assign o_lane      = i_restart ? 2'd0 : o_pos;
   assign o_word_done = i_consume && (o_lane == last_lane(i_pclk));

   // Next counter value: advance on consume, wrap after the last lane.
   always_comb begin
      w_cnt_nxt = o_pos;
      if (i_consume) begin
         if (o_word_done) begin
            w_cnt_nxt = 2'd0;
         end else begin
            w_cnt_nxt = o_lane + 2'd1;
         end
      end else begin
         w_cnt_nxt = o_pos;
      end
   end

   // Counter and previous width-select registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt       <= 2'd0;
         r_pclk_prev <= W32;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_pclk_prev <= i_pclk;
      end
   end

endmodule

// File: rtl/conv_8a32_rx.sv
// -----------------------------------------------------------------------------
// conv_8a32_rx
// Receive-side byte-to-word packer. Aligns on a COM K-symbol and packs
// 8-bit symbols into 32/16/8-bit words; the first byte of a word lands in
// the most-significant used lane.
// Optional feature macro: COM_REALIGN_EN -- a COM seen mid-word while
// aligned restarts the word at lane 0 and pulses align_err.
// Ports:
//   CLK              rising-edge clock
//   RESET_CONV832RX  synchronous active-low reset
//   ENB              symbol valid
//   PCLK             width select: 00=32, 01=16, 10/11=8 bits
//   in, K            received symbol and its K flag
//   out, K_out       assembled word and per-lane K flags (bit 3 = out[31:24])
//   valid_out        one-cycle pulse when out/K_out update
//   aligned          high once a COM has been seen
//   align_err        one-cycle realignment pulse (0 without the macro)
// -----------------------------------------------------------------------------
module conv_8a32_rx
   import conv_8a32_rx_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET_CONV832RX,
   input  logic             ENB,
   input  logic [1:0]       PCLK,
   input  logic [7:0]       in,
   input  logic             K,
   output logic [OUT_W-1:0] out,
   output logic [3:0]       K_out,
   output logic             valid_out,
   output logic             aligned,
   output logic             align_err
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0][7:0]  r_byte;      // indexed by lane (0 = first byte)
   logic [3:0]       r_klane;
   logic [OUT_W-1:0] r_out;
   logic [3:0]       r_kout;
   logic             r_valid;
   logic             r_aligned;
   logic             r_err;

   logic             w_is_com;
   logic             w_consume;
   logic             w_restart;
   logic             w_err;
   logic [1:0]       w_pos;
   logic [1:0]       w_lane;
   logic             w_word_done;
   logic [3:0][7:0]  w_bytes;
   logic [3:0]       w_kl;
   logic [OUT_W-1:0] w_word;
   logic [3:0]       w_kword;

   assign w_is_com = K && (in == COM_SYM);

   conv_8a32_lane_ctrl u_lane_ctrl (
      .i_clk       (CLK),
      .i_rst_n     (RESET_CONV832RX),
      .i_consume   (w_consume),
      .i_restart   (w_restart),
      .i_pclk      (PCLK),
      .o_pos       (w_pos),
      .o_lane      (w_lane),
      .o_word_done (w_word_done)
   );

   // Alignment FSM next state and per-cycle consume/restart decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_consume   = 1'b0;
      w_restart   = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         UNALIGNED: begin
            if (ENB && w_is_com) begin
               w_state_nxt = ALIGNED;
               w_consume   = 1'b1;
               w_restart   = 1'b1;
            end else begin
               w_state_nxt = UNALIGNED;
            end
         end
         ALIGNED: begin
            w_consume = ENB;
`ifdef COM_REALIGN_EN
            if (ENB && w_is_com && (w_pos != 2'd0)) begin
               w_restart = 1'b1;
               w_err     = 1'b1;
            end else begin
               w_restart = 1'b0;
            end
`endif
         end
         default: begin
            w_state_nxt = UNALIGNED;
         end
      endcase
   end

   // Word assembly: stored lanes with the current symbol merged in.
   always_comb begin
      w_bytes         = r_byte;
      w_kl            = r_klane;
      w_bytes[w_lane] = in;
      w_kl[w_lane]    = K;
      case (PCLK)
         W32: begin
            w_word  = {w_bytes[0], w_bytes[1], w_bytes[2], w_bytes[3]};
            w_kword = {w_kl[0], w_kl[1], w_kl[2], w_kl[3]};
         end
         W16: begin
            w_word  = {16'h0000, w_bytes[0], w_bytes[1]};
            w_kword = {2'b00, w_kl[0], w_kl[1]};
         end
         default: begin
            w_word  = {24'h000000, w_bytes[0]};
            w_kword = {3'b000, w_kl[0]};
         end
      endcase
   end

   // State, lane storage and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RESET_CONV832RX) begin
         r_state   <= UNALIGNED;
         r_byte    <= '0;
         r_klane   <= 4'b0000;
         r_out     <= '0;
         r_kout    <= 4'b0000;
         r_valid   <= 1'b0;
         r_aligned <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_aligned <= (w_state_nxt == ALIGNED);
         r_valid   <= w_word_done;
         r_err     <= w_err;
         if (w_consume) begin
            r_byte[w_lane]  <= in;
            r_klane[w_lane] <= K;
         end
         if (w_word_done) begin
            r_out  <= w_word;
            r_kout <= w_kword;
         end
      end
   end

   assign out       = r_out;
   assign K_out     = r_kout;
   assign valid_out = r_valid;
   assign aligned   = r_aligned;
   assign align_err = r_err;

endmodule

// File: doc/conv_8a32_rx.md
Name: conv_8a32_rx

Overview:
Receive-side byte-to-word packer for the PCIe-over-USB PHY. It sits after the serial-to-parallel block and takes one 8-bit symbol per CLK cycle together with its K flag. It aligns word boundaries on a COM symbol and reassembles 32-, 16- or 8-bit words, selected by PCLK. It is the inverse of the transmit-side 32-to-8 converter.

Parameters:
COM_SYM, 8'hBC, K-symbol that marks byte lane 0 of a word.
OUT_W, 32, output word width; fixed, not to be overridden.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RESET_CONV832RX  input  1  synchronous reset, active-low.
ENB  input  1  symbol valid. When high, `in`/`K` are consumed this cycle.
PCLK  input  2  width select: 00 = 32 bits, 01 = 16 bits, 10 = 8 bits, 11 = 8 bits (reserved).
in  input  8  received symbol.
K  input  1  1 = `in` is a control (K) symbol.
out  output  32  assembled word.
K_out  output  4  per-lane K flags; bit 3 maps to out[31:24].
valid_out  output  1  one-cycle pulse when out/K_out hold a new word.
aligned  output  1  high once a COM has been seen.
align_err  output  1  one-cycle pulse; active only with the optional feature.

Behaviour:
- Reset (RESET_CONV832RX = 0 at a rising edge):
  - Outputs: out = 0, K_out = 0, valid_out = 0, aligned = 0, align_err = 0.
  - Internal state: byte counter = 0, partial word cleared, FSM = UNALIGNED.
  - Reset mid-word discards the partial word; nothing is emitted.
- Word size N = 4 / 2 / 1 bytes for PCLK = 00 / 01 / 10 (11 behaves as 10).
- Byte order: the first byte of a word goes to the most-significant used lane.
  - 32-bit mode: lanes are out[31:24], [23:16], [15:8], [7:0].
  - 16-bit mode: lanes are out[15:8], [7:0]; out[31:16] = 0 and K_out[3:2] = 0.
  - 8-bit mode: out[7:0] only; upper bits 0.
- ENB = 0: nothing is consumed. The counter and partial word hold, and valid_out = 0.
- FSM UNALIGNED:
  - Symbols with ENB = 1 are discarded.
  - When K = 1 and in = COM_SYM, go to ALIGNED. That COM is stored as lane 0 and the counter becomes 1.
  - aligned rises in the cycle after the COM is sampled.
  - In 8-bit mode the COM completes a word immediately.
- FSM ALIGNED:
  - Each consumed symbol is written into lane[counter] and the counter increments.
  - When the counter reaches N-1 and a symbol is consumed:
    - out/K_out are registered with the full word.
    - valid_out = 1 on the next cycle (latency: 1 CLK from the last byte sampled to valid_out).
    - The counter wraps to 0.
  - out and K_out hold their value between valid_out pulses.
- PCLK change (compared with the value registered on the previous cycle):
  - Discard the partial word and set the counter to 0. The FSM stays ALIGNED.
  - The symbol on the change cycle is treated as lane 0 of the new width.
- Same cycle as wrap: a COM on the lane-0 position after a wrap is ordinary data.
- No error detection beyond the optional feature. A K symbol other than COM is passed through with its K_out bit set.

Optional Feature:
Macro COM_REALIGN_EN.
- Defined: in ALIGNED, a COM (K = 1, in = COM_SYM) consumed at counter != 0 does three things:
  - discards the partial word;
  - is stored as lane 0, with counter = 1;
  - pulses align_err for one cycle on the next cycle. No valid_out is generated for the discarded bytes.
- Not defined: a COM at any position is stored as ordinary data, and align_err is tied to 0.

Decomposition:
- Shared package:
  - PCLK encodings W32 = 2'b00, W16 = 2'b01, W8 = 2'b10;
  - COM_SYM = 8'hBC;
  - FSM state constants UNALIGNED and ALIGNED.
- One sub-module, conv_8a32_lane_ctrl: the byte counter, wrap and PCLK-change detection, producing lane index and word_done.
- The top level holds the FSM, lane registers and output registers.

Test Plan:
- Reset, then ENB = 1, PCLK = 00, send BC(K) 0F 00 FF → valid_out one cycle after FF; out = BC0F00FF, K_out = 1000, aligned = 1.
- Unaligned garbage 55 AA before the COM, then BC(K) 3C EA FF 4A 0F F0 FF → first word out = BC3CEAFF, second word 4A0FF0FF; the garbage bytes are never emitted.
- PCLK = 01 stream BC(K) 30 E0 EA → two pulses, out = 0000BC30 then 0000E0EA; upper bits 0.
- ENB low for 3 cycles between bytes 2 and 3 of a 32-bit word → same word as with no gap, with valid_out delayed by 3 cycles.
- Reset asserted after 2 bytes of a word → no valid_out, aligned = 0, all outputs 0. After release, a new BC is needed before any word is emitted.
- With COM_REALIGN_EN: aligned, send AA 55 BC(K) 01 02 03 → align_err pulses once; the next word is BC010203. Without the macro, the same stream gives AA55BC01, with K_out = 0010.
